// File: rtl/dino_pkg.sv
// Shared types and geometry constants for the dino-run game datapath.
package dino_pkg;

  localparam int HACTIVE = 1280;
  localparam int XW      = 11;

  typedef enum logic [1:0] {
    SLOT_SCAC  = 2'd0,
    SLOT_GROUP = 2'd1,
    SLOT_LAVA  = 2'd2,
    SLOT_PTERO = 2'd3
  } slot_idx_t;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_PICK = 1'b1
  } sched_state_t;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous reload; shared by the random consumers.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hAC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       advance,
  output logic [7:0] lfsr,
  output logic [7:0] lfsr_next
);

  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        lfsr <= SEED;
    else if (load)    lfsr <= SEED;
    else if (advance) lfsr <= lfsr_next;
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// Frame-locked obstacle slot scheduler: motion, retirement, spawn picking, speed ramp.
// Define OBSTACLE_SCHED_JITTER_EN to add a random 0..63 px jitter to the spawn gap.
module obstacle_scheduler #(
  parameter int         NUM_SLOTS        = 4,
  parameter int         HACTIVE          = 1280,
  parameter int         MIN_GAP          = 200,
  parameter int         SPEED_STEP_COUNT = 12,
  parameter int         MAX_SPEED        = 8,
  parameter logic [7:0] LFSR_SEED        = 8'hAC
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              frame_tick,
  input  logic                              run,
  input  logic                              restart,
  input  logic [NUM_SLOTS-1:0]              kill,
  output logic [NUM_SLOTS*dino_pkg::XW-1:0] slot_x,
  output logic [NUM_SLOTS-1:0]              slot_active,
  output logic [3:0]                        speed,
  output logic [4:0]                        passed_count,
  output logic                              spawn_pulse
);
  import dino_pkg::*;

  localparam logic [XW-1:0] X_PARK  = XW'(HACTIVE);
  localparam logic [10:0]   GAP_MAX = 11'd2047;

  sched_state_t         state_reg;
  logic [10:0]          gap_cnt_reg;
  logic [10:0]          gap_next;
  logic [11:0]          gap_wide;
  logic [11:0]          gap_target;
  logic [1:0]           cand_reg;
  logic [1:0]           tries_reg;
  logic [7:0]           lfsr_q;
  logic [7:0]           lfsr_next;
  logic                 lfsr_unused;
  logic                 tick_go;
  logic                 pick_go;
  logic                 spawn_go;
  logic [NUM_SLOTS-1:0] retire;
  logic [2:0]           retire_cnt;
  logic [5:0]           passed_sum;
  logic                 speed_step;

  assign tick_go  = run && frame_tick && (state_reg == S_RUN);
  assign pick_go  = run && (state_reg == S_PICK);
  assign spawn_go = pick_go && !slot_active[cand_reg];

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .load      (restart),
    .advance   (tick_go),
    .lfsr      (lfsr_q),
    .lfsr_next (lfsr_next)
  );
  assign lfsr_unused = ^{lfsr_q, lfsr_next[7:2]};

  // Retirement wins over motion and spawn, so a kill landing on a leaving slot counts once.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    logic [XW-1:0] x_reg;
    logic          active_reg;
    logic          motion_retire;

    assign motion_retire = tick_go && active_reg && (x_reg <= XW'(speed));
    assign retire[gi]    = run && active_reg && (kill[gi] || motion_retire);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        x_reg      <= X_PARK;
        active_reg <= 1'b0;
      end else if (restart) begin
        x_reg      <= X_PARK;
        active_reg <= 1'b0;
      end else if (retire[gi]) begin
        x_reg      <= X_PARK;
        active_reg <= 1'b0;
      end else if (tick_go && active_reg) begin
        x_reg <= x_reg - XW'(speed);
      end else if (spawn_go && (cand_reg == 2'(gi))) begin
        x_reg      <= X_PARK;
        active_reg <= 1'b1;
      end
    end

    assign slot_x[gi*XW +: XW] = x_reg;
    assign slot_active[gi]     = active_reg;
  end

  always_comb begin
    retire_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      retire_cnt = retire_cnt + {2'b00, retire[i]};
  end

  assign passed_sum = {1'b0, passed_count} + {3'b000, retire_cnt};
  assign speed_step = passed_sum >= 6'(SPEED_STEP_COUNT);
  assign gap_wide   = {1'b0, gap_cnt_reg} + {8'd0, speed};
  assign gap_next   = gap_wide[11] ? GAP_MAX : gap_wide[10:0];

`ifdef OBSTACLE_SCHED_JITTER_EN
  logic [5:0] jitter_reg;
  assign gap_target = 12'(MIN_GAP) + {6'd0, jitter_reg};
`else
  assign gap_target = 12'(MIN_GAP);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_RUN;
      gap_cnt_reg  <= 11'(MIN_GAP);
      cand_reg     <= '0;
      tries_reg    <= '0;
      speed        <= 4'd1;
      passed_count <= '0;
      spawn_pulse  <= 1'b0;
`ifdef OBSTACLE_SCHED_JITTER_EN
      jitter_reg   <= '0;
`endif
    end else if (restart) begin
      state_reg    <= S_RUN;
      gap_cnt_reg  <= 11'(MIN_GAP);
      cand_reg     <= '0;
      tries_reg    <= '0;
      speed        <= 4'd1;
      passed_count <= '0;
      spawn_pulse  <= 1'b0;
`ifdef OBSTACLE_SCHED_JITTER_EN
      jitter_reg   <= '0;
`endif
    end else begin
      spawn_pulse <= 1'b0;
      if (run) begin
        if (speed_step) begin
          passed_count <= '0;
          if (speed < 4'(MAX_SPEED)) speed <= speed + 4'd1;
        end else begin
          passed_count <= passed_sum[4:0];
        end

        case (state_reg)
          S_RUN: begin
            if (frame_tick) begin
              gap_cnt_reg <= gap_next;
              if ({1'b0, gap_next} >= gap_target) begin
                state_reg <= S_PICK;
                cand_reg  <= lfsr_next[1:0];
                tries_reg <= '0;
`ifdef OBSTACLE_SCHED_JITTER_EN
                jitter_reg <= lfsr_q[7:2];
`endif
              end
            end
          end
          S_PICK: begin
            if (!slot_active[cand_reg]) begin
              gap_cnt_reg <= '0;
              spawn_pulse <= 1'b1;
              state_reg   <= S_RUN;
            end else begin
              // Gap count is left untouched so the next tick retries immediately.
              cand_reg  <= cand_reg + 2'd1;
              tries_reg <= tries_reg + 2'd1;
              if (tries_reg == 2'd3) state_reg <= S_RUN;
            end
          end
          default: state_reg <= S_RUN;
        endcase
      end
    end
  end

endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
Frame-locked scheduler that owns the horizontal positions of the four obstacle slots: small cactus, cactus group, lava and pterodactyl. On each frame tick it advances active obstacles and retires the ones that leave the screen. It decides when, and into which free slot, the next obstacle spawns, enforcing a minimum on-screen gap. It also ramps scroll speed with the count of obstacles passed. It sits between the VGA frame-tick source and the draw/collision logic in the dino-run top level.

Parameters:
NUM_SLOTS, 4, obstacle slots; fixed at 4 (index 0 scac, 1 group, 2 lava, 3 ptero)
HACTIVE, 1280, spawn x coordinate / off-screen park position
MIN_GAP, 200, pixels of scroll required between consecutive spawns
SPEED_STEP_COUNT, 12, passed obstacles per speed increment
MAX_SPEED, 8, speed saturation value
LFSR_SEED, 8'hAC, LFSR reset value

Ports:
clk  in  1  system clock
reset  in  1  reset
frame_tick  in  1  one-cycle pulse per frame (VSYNC rising edge)
run  in  1  high while playing; low freezes all scheduling
restart  in  1  one-cycle pulse; synchronous re-init
kill  in  NUM_SLOTS  per-slot destroy request (Godzilla hit)
slot_x  out  NUM_SLOTS*11  packed x positions, slot i at [11i+10:11i]
slot_active  out  NUM_SLOTS  slot holds an on-screen obstacle
speed  out  4  current pixels/frame
passed_count  out  5  obstacles retired since last speed step
spawn_pulse  out  1  one-cycle pulse when a spawn commits

Interface: reset reset, asynchronous, active-high; clock clk.

Behaviour:
- Reset and restart values: slot_x all = HACTIVE; slot_active = 0; speed = 1; passed_count = 0; gap_cnt (11 b, internal) = MIN_GAP; lfsr = LFSR_SEED; state = S_RUN; spawn_pulse = 0.
- restart takes priority over every other input and is honoured regardless of run.
- LFSR: 8-bit, next = {lfsr[6:0], lfsr[7]^lfsr[5]}. Advances only on accepted frame_tick.
- States: S_RUN, S_PICK.
- S_RUN, on frame_tick && run (cycle T, results registered at T+1):
  - For each active slot: if x > speed, x -= speed; else x <= HACTIVE, active <= 0, retire.
  - gap_cnt += speed, saturating at 2047.
  - If the updated gap_cnt >= gap target, go to S_PICK with cand = next_lfsr[1:0] and tries = 0.
- S_PICK, one cycle per attempt:
  - If slot[cand] is inactive: slot_x[cand] <= HACTIVE, active <= 1, gap_cnt <= 0, spawn_pulse for one cycle, go to S_RUN.
  - Otherwise cand <= cand+1 mod 4 and tries++.
  - After 4 failed attempts, go to S_RUN with no spawn. gap_cnt is held, so a retry happens on the next tick.
- frame_tick arriving while in S_PICK is ignored (the pick completes within 4 cycles).
- kill[i] on an active slot: retire slot i that cycle. kill on an inactive slot is ignored.
- kill and a motion retirement of the same slot in the same cycle count as one retirement.
- Multiple retirements in one cycle add their total to passed_count.
- Speed step: when passed_count + retirements >= SPEED_STEP_COUNT, passed_count <= 0 and speed <= min(speed+1, MAX_SPEED). The remainder is discarded.
- run = 0: frame_tick is ignored, kill is ignored, all state is frozen. An in-flight S_PICK also freezes.
- Gap target = MIN_GAP, or MIN_GAP + jitter when the optional feature is enabled.

Optional Feature:
Macro OBSTACLE_SCHED_JITTER_EN.
- Defined: on entering S_PICK, latch jitter = lfsr[7:2] (0..63). The next spawn requires gap_cnt >= MIN_GAP + jitter.
- Undefined: the target is the constant MIN_GAP and no jitter register exists.

Decomposition:
- Package dino_pkg:
  - HACTIVE
  - slot index enum (SLOT_SCAC, SLOT_GROUP, SLOT_LAVA, SLOT_PTERO)
  - sched_state_t {S_RUN, S_PICK}
  - x-coordinate width constant (11)
- Sub-module lfsr8: seed parameter plus advance enable. It is shared with other random consumers in the top level.

Test Plan:
- Reset, then one frame_tick with run = 1 -> lfsr = 8'h58, cand = 0; spawn_pulse at T+2; slot_active = 4'b0001; slot_x[0] = 1280; gap_cnt = 0.
- Slot 0 active at x = 3 with speed = 4, frame_tick -> slot 0 inactive, x = 1280, passed_count +1.
- passed_count = 11, one retirement -> passed_count = 0, speed 1 -> 2. With speed = 8 the same event leaves speed at 8.
- All four slots active and gap met -> 4 S_PICK cycles, no spawn_pulse, gap_cnt unchanged; a spawn follows the first tick after a retirement.
- kill[2] and motion retirement of slot 2 in the same cycle -> passed_count +1 exactly; kill[1] on an inactive slot -> no change.
- restart during S_PICK -> next cycle: all reset values, state S_RUN. run = 0 with frame_tick -> slot_x, speed and lfsr unchanged.
